// File: rtl/stim_pkg.sv
// stim_pkg: shared types for the stimulus sequencer.
// Playback state encoding and mode constants.
`timescale 1ns/1ps
package stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ONESHOT = 1'b0;
  localparam logic LOOP    = 1'b1;

endpackage

// File: rtl/stim_ram.sv
// stim_ram: stimulus table, one write port,
// asynchronous read, contents survive reset.
`timescale 1ns/1ps
module stim_ram
  import stim_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 11,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // table write, gated upstream to IDLE and legal addresses
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stim_sequencer.sv
// stim_sequencer: plays a programmed vector table into a DUT,
// one vector per clock, with loop, pause and abort control.
`timescale 1ns/1ps
module stim_sequencer
  import stim_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 11,
  parameter  int CW    = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld_we,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW:0]      cfg_len,
  input  logic             cfg_loop,
  input  logic [CW-1:0]    cfg_loops,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] stim,
  output logic             stim_valid,
  output logic [AW-1:0]    pc,
  output logic [CW-1:0]    step,
  output logic             done
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t           state;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    len_m1;
  logic             loop_mode;
  logic [CW-1:0]    loops;
  logic [CW-1:0]    passes;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      eff_len;
  logic             wr_en;
  logic             last;
  logic             fin;

  // 0 or oversized length plays the whole table
  assign eff_len = (cfg_len == '0 || cfg_len > DEPTH_W)
                 ? DEPTH_W : cfg_len;

  assign wr_en = ld_we && (state == IDLE)
              && ({1'b0, ld_addr} < DEPTH_W);

  assign last = (rd_ptr == len_m1);

  // loops == 0 in loop mode never finishes
  assign fin = (loop_mode == ONESHOT)
            || (loops != '0 && passes == loops);

  stim_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // playback FSM with registered outputs and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      len_m1     <= '0;
      loop_mode  <= ONESHOT;
      loops      <= '0;
      passes     <= '0;
      stim       <= '0;
      stim_valid <= 1'b0;
      pc         <= '0;
      step       <= '0;
      done       <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      stim_valid <= 1'b0;
      done       <= 1'b0;
    end else if (start && state != RUN) begin
      state      <= RUN;
      rd_ptr     <= '0;
      len_m1     <= AW'(eff_len - (AW+1)'(1));
      loop_mode  <= cfg_loop;
      loops      <= cfg_loops;
      passes     <= '0;
      step       <= '0;
      stim_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: stim_valid <= 1'b0;
        RUN: begin
          if (pause) begin
            stim_valid <= 1'b0;
          end else begin
            stim       <= rd_data;
            pc         <= rd_ptr;
            stim_valid <= 1'b1;
            if (step != '1) step <= step + CW'(1);
            if (!last) begin
              rd_ptr <= rd_ptr + AW'(1);
            end else if (fin) begin
              state <= DONE;
            end else begin
              rd_ptr <= '0;
              if (passes != '1) passes <= passes + CW'(1);
            end
          end
        end
        DONE: begin
          stim_valid <= 1'b0;
          done       <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer: randomized playback checks against
// a queue-based model of the expected vector stream.
`timescale 1ns/1ps
module tb_stim_sequencer;

  localparam int WIDTH = 3;
  localparam int DEPTH = 11;
  localparam int AW    = 4;
  localparam int CW    = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             ld_we = 1'b0;
  logic [AW-1:0]    ld_addr = '0;
  logic [WIDTH-1:0] ld_data = '0;
  logic [AW:0]      cfg_len = '0;
  logic             cfg_loop = 1'b0;
  logic [CW-1:0]    cfg_loops = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] stim;
  logic             stim_valid;
  logic [AW-1:0]    pc;
  logic [CW-1:0]    step;
  logic             done;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_stim = '0;
  logic [AW-1:0]    exp_pc = '0;

  always #5 clock = ~clock;

  stim_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .cfg_len    (cfg_len),
    .cfg_loop   (cfg_loop),
    .cfg_loops  (cfg_loops),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .stim       (stim),
    .stim_valid (stim_valid),
    .pc         (pc),
    .step       (step),
    .done       (done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic load_entry(input int a, input logic [WIDTH-1:0] d);
    ld_we = 1'b1;
    ld_addr = a[AW-1:0];
    ld_data = d;
    tick();
    ld_we = 1'b0;
    if (a < DEPTH) ref_mem[a] = d;
  endtask

  task automatic run_seq(
    input string name,
    input int len_cfg,
    input bit lp,
    input int loops,
    input int pause_pct,
    input int pause_at,
    input int pause_n,
    input bit start_pause,
    input bit we_during
  );
    int eff;
    int passes;
    int q[$];
    int idx;
    int stp;
    int pleft;
    int guard;
    bit inf;
    bit p;
    eff = (len_cfg == 0 || len_cfg > DEPTH) ? DEPTH : len_cfg;
    inf = lp && loops == 0;
    passes = !lp ? 1 : (inf ? (40 / eff) + 1 : loops + 1);
    for (int r = 0; r < passes; r++)
      for (int i = 0; i < eff; i++) q.push_back(i);
    cfg_len = len_cfg[AW:0];
    cfg_loop = lp;
    cfg_loops = CW'(loops);
    start = 1'b1;
    pause = start_pause;
    tick();
    start = 1'b0;
    pause = 1'b0;
    idx = 0;
    stp = 0;
    pleft = pause_n;
    guard = 0;
    while (idx < q.size()) begin
      guard++;
      if (guard > 1000) begin
        checks++;
        failures++;
        $display("FAIL %s timeout: idx=%0d of %0d", name, idx, q.size());
        break;
      end
      p = 1'b0;
      if (idx == pause_at && pleft > 0) begin
        p = 1'b1;
        pleft--;
      end else if ($urandom_range(0, 99) < pause_pct) begin
        p = 1'b1;
      end
      if (we_during) begin
        ld_we = 1'b1;
        ld_addr = AW'($urandom_range(0, DEPTH - 1));
        ld_data = WIDTH'($urandom);
      end
      pause = p;
      tick();
      pause = 1'b0;
      if (!p) begin
        exp_stim = ref_mem[q[idx]];
        exp_pc = AW'(q[idx]);
        stp++;
        idx++;
      end
      checks++;
      if (stim_valid !== !p || stim !== exp_stim || pc !== exp_pc
          || step !== CW'(stp) || done !== 1'b0) begin
        failures++;
        $display("FAIL %s vec%0d pause=%0b: valid=%b stim=%h pc=%0d step=%0d done=%b want valid=%b stim=%h pc=%0d step=%0d done=0",
                 name, idx, p, stim_valid, stim, pc, step, done,
                 !p, exp_stim, exp_pc, stp);
      end
    end
    if (inf) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (stim_valid !== 1'b0 || done !== 1'b0 || stim !== exp_stim) begin
        failures++;
        $display("FAIL %s inf_abort: valid=%b done=%b stim=%h want 0 0 %h",
                 name, stim_valid, done, stim, exp_stim);
      end
    end else begin
      tick();
      checks++;
      if (done !== 1'b1 || stim_valid !== 1'b0 || stim !== exp_stim
          || pc !== exp_pc || step !== CW'(stp)) begin
        failures++;
        $display("FAIL %s done: done=%b valid=%b stim=%h pc=%0d step=%0d want 1 0 %h %0d %0d",
                 name, done, stim_valid, stim, pc, step, exp_stim, exp_pc, stp);
      end
    end
    ld_we = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (stim !== '0 || stim_valid !== 1'b0 || pc !== '0
        || step !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset: stim=%h valid=%b pc=%0d step=%0d done=%b want all 0",
               stim, stim_valid, pc, step, done);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_oneshot_full();
    for (int i = 0; i < DEPTH; i++) load_entry(i, WIDTH'(i));
    run_seq("oneshot", 0, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_loop();
    go_idle();
    load_entry(0, 3'b101);
    load_entry(1, 3'b110);
    load_entry(2, 3'b111);
    run_seq("loop3x3", 3, 1'b1, 2, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_pause();
    run_seq("pause4", 0, 1'b0, 0, 0, 2, 4, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    cfg_len = '0;
    cfg_loop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (stim_valid !== 1'b1 || stim !== ref_mem[k] || pc !== AW'(k)
          || step !== CW'(k + 1)) begin
        failures++;
        $display("FAIL abort_pre%0d: valid=%b stim=%h pc=%0d step=%0d want 1 %h %0d %0d",
                 k, stim_valid, stim, pc, step, ref_mem[k], k, k + 1);
      end
    end
    exp_stim = ref_mem[4];
    exp_pc = AW'(4);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (stim_valid !== 1'b0 || done !== 1'b0 || stim !== exp_stim) begin
      failures++;
      $display("FAIL abort: valid=%b done=%b stim=%h want 0 0 %h",
               stim_valid, done, stim, exp_stim);
    end
    tick();
    checks++;
    if (stim_valid !== 1'b0 || stim !== exp_stim) begin
      failures++;
      $display("FAIL abort_idle: valid=%b stim=%h want 0 %h",
               stim_valid, stim, exp_stim);
    end
    run_seq("after_abort", 0, 1'b0, 0, 10, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cfg_len = '0;
    cfg_loop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (stim !== '0 || stim_valid !== 1'b0 || pc !== '0
        || step !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: stim=%h valid=%b pc=%0d step=%0d done=%b want all 0",
               stim, stim_valid, pc, step, done);
    end
    exp_stim = '0;
    exp_pc = '0;
    @(negedge clock);
    reset = 1'b1;
    tick();
    run_seq("after_reset", 0, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_load_guard();
    run_seq("we_run", 0, 1'b0, 0, 20, -1, 0, 1'b0, 1'b1);
    run_seq("readback", 0, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0);
    go_idle();
    load_entry(11, ~ref_mem[0]);
    load_entry(15, ~ref_mem[10]);
    run_seq("oob_readback", 0, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_len1();
    run_seq("len1_oneshot", 1, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0);
    run_seq("len1_loop", 1, 1'b1, 3, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_start_beats_pause();
    run_seq("start_pause", 0, 1'b0, 0, 0, -1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      go_idle();
      for (int i = 0; i < DEPTH; i++) load_entry(i, WIDTH'($urandom));
      run_seq("rand", $urandom_range(0, 31), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 25, -1, 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_oneshot_full();
    test_loop();
    test_pause();
    test_abort();
    test_reset_mid();
    test_load_guard();
    test_len1();
    test_start_beats_pause();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
- Synthesizable, parametrised stimulus sequencer for the concolic test flow.
- Plays a programmed table of input vectors into a DUT's primary inputs, one vector per clock.
- Supports configurable width, depth, sequence length, looping, pause and abort.
- Sits between the bench or loader and the DUT input ports; a step counter and done flag go back to the harness for trace alignment.

Parameters:
- WIDTH, 3, bits per stimulus vector (DUT input count incl. __obs)
- DEPTH, 11, table entries
- AW, $clog2(DEPTH), table/pc address width (derived, not overridden)
- CW, 32, width of step and loop counters

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ld_we  in  1  table write strobe; honoured only in IDLE
- ld_addr  in  AW  table write address; writes with ld_addr >= DEPTH are ignored
- ld_data  in  WIDTH  table write data
- cfg_len  in  AW+1  sequence length, sampled on start; 0 or >DEPTH means DEPTH
- cfg_loop  in  1  0 = one-shot, 1 = loop; sampled on start
- cfg_loops  in  CW  loop passes, sampled on start; 0 = infinite (loop mode only)
- start  in  1  begin playback; honoured in IDLE and DONE
- pause  in  1  freeze playback while high
- abort  in  1  return to IDLE
- stim  out  WIDTH  current vector to DUT
- stim_valid  out  1  stim was refreshed this cycle
- pc  out  AW  index of the entry now on stim
- step  out  CW  vectors issued since start
- done  out  1  sequence completed

Behaviour:
- Reset (reset low, async): state = IDLE; stim, stim_valid, pc, step, done = 0; internal pass counter = 0. Table contents are not reset.
- States: IDLE, RUN, DONE.
- IDLE: table writable. start -> RUN, latch cfg values, rd_ptr = 0, step = 0, done = 0.
- Latency: start sampled at edge t gives stim = mem[0], stim_valid = 1, pc = 0 after edge t+1. Each subsequent unpaused edge issues the next entry and increments step.
- RUN, no pause: issue mem[rd_ptr]. When rd_ptr == len-1, the same edge decides what follows:
  - one-shot, or loop with passes done == cfg_loops: next state DONE, done = 1 on the following edge, stim holds the last vector.
  - otherwise: rd_ptr wraps to 0 and the pass count increments; back-to-back, no bubble.
- pause high in RUN: no advance; stim, pc and step hold; stim_valid = 0. Resumes on the first edge with pause low.
- DONE: stim holds the last vector, stim_valid = 0, done = 1. start restarts as in IDLE, clearing done.
- abort, any state: next edge goes to IDLE; stim_valid = 0 and done = 0; stim holds its value. abort beats start, and start beats pause.
- ld_we outside IDLE is ignored; the table never changes during playback.
- step saturates at 2^CW-1. The pass counter never wraps when cfg_loops = 0 (infinite).
- len = 1: the same vector is issued each cycle; one-shot finishes after one vector.
- Reset mid-playback: immediate return to reset values; the table is retained.

Decomposition:
- Shared package stim_pkg: state enum (IDLE/RUN/DONE) and the mode constants ONESHOT/LOOP.
- One sub-module, stim_ram: single write port, asynchronous read, DEPTH x WIDTH, no reset.
- Sequencing FSM and counters stay in stim_sequencer.

Test Plan:
- Load 11 entries 000..010 (one-shot, cfg_len 0), pulse start -> stim runs 000..010 on 11 consecutive edges with stim_valid = 1, then done = 1, stim = 010, step = 11.
- cfg_len 3, cfg_loop 1, cfg_loops 2, table 101,110,111 -> 9 vectors 101,110,111 ×3 with no gap, then done, step = 9.
- Pause high for 4 cycles after the 2nd vector -> stim and step frozen, stim_valid = 0 for 4 cycles, then the 3rd vector issues.
- Abort during the 5th vector with start also high -> IDLE, done = 0, stim_valid = 0. A later start replays from mem[0].
- Assert reset low mid-run, asynchronously between edges -> outputs 0 immediately. After release, start replays the unchanged table.
- ld_we with new data during RUN -> mem unchanged; the readback run matches the original table. ld_addr = 11 in IDLE is ignored.
